// File: rtl/ps2_multi_tx.sv
// ps2_multi_tx: multi-channel PS/2 device-side transmitter, one byte FIFO and frame FSM per channel.
// Define PS2_INHIBIT_EN to honour host inhibit (abort, wait for release plus GAP, retransmit).
module ps2_multi_tx #(
   parameter int CHANNELS  = 2,
   parameter int FIFO_BITS = 3,
   parameter int CLK_DIV   = 50
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                wr_en,
   input  logic [1:0]          wr_chan,
   input  logic [7:0]          wr_data,
   output logic [CHANNELS-1:0] fifo_full,
   output logic [CHANNELS-1:0] overflow,
   output logic [CHANNELS-1:0] tx_busy,
   input  logic [CHANNELS-1:0] ps2_clk_in,
   output logic [CHANNELS-1:0] ps2_clk_out,
   output logic [CHANNELS-1:0] ps2_data_out
);
   localparam int DEPTH = 1 << FIFO_BITS;
   localparam int PW    = FIFO_BITS + 1;
   localparam int DIV_W = $clog2(2 * CLK_DIV);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP, S_HOLD
   } state_t;

`ifndef PS2_INHIBIT_EN
   logic unused_clk_in;
   assign unused_clk_in = ^ps2_clk_in;
`endif

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         logic [7:0]    mem [DEPTH];
         logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
         logic          full_q, full_d, ovf_q;
         logic          wr_hit, do_wr, do_pop, do_start, may_start, empty;
         logic          inhibit, released, bit_end, half_end;
         state_t        state_q;
         logic [DIV_W-1:0] div_q;
         logic [2:0]    bit_q;
         logic [7:0]    hold_q;
         logic          retx_q, clk_o_q, data_o_q;

         assign wr_hit   = wr_en && (wr_chan == 2'(gi));
         assign do_wr    = wr_hit && !full_q;
         assign empty    = (wr_ptr_q == rd_ptr_q);
         assign wr_ptr_d = wr_ptr_q + PW'(do_wr);
         assign rd_ptr_d = rd_ptr_q + PW'(do_pop);
         assign full_d   = (wr_ptr_d[FIFO_BITS] != rd_ptr_d[FIFO_BITS]) &&
                           (wr_ptr_d[FIFO_BITS-1:0] == rd_ptr_d[FIFO_BITS-1:0]);

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               wr_ptr_q <= '0;
               rd_ptr_q <= '0;
               full_q   <= 1'b0;
               ovf_q    <= 1'b0;
            end else begin
               wr_ptr_q <= wr_ptr_d;
               rd_ptr_q <= rd_ptr_d;
               full_q   <= full_d;
               if (wr_hit && full_q) ovf_q <= 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (do_wr) mem[wr_ptr_q[FIFO_BITS-1:0]] <= wr_data;
         end

`ifdef PS2_INHIBIT_EN
         logic sync1_q, sync2_q;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               sync1_q <= 1'b1;
               sync2_q <= 1'b1;
            end else begin
               sync1_q <= ps2_clk_in[gi];
               sync2_q <= sync1_q;
            end
         end
         // Only a low line while we are releasing the clock is the host's doing.
         assign inhibit  = !sync2_q && clk_o_q;
         assign released = sync2_q;
`else
         assign inhibit  = 1'b0;
         assign released = 1'b1;
`endif

         assign bit_end  = (div_q == DIV_W'(2 * CLK_DIV - 1));
         assign half_end = (div_q == DIV_W'(CLK_DIV - 1));
         // The end of GAP doubles as an IDLE decision point so frames can chain back-to-back.
         assign may_start = (state_q == S_IDLE) || (state_q == S_GAP && bit_end);
         assign do_start  = may_start && !inhibit && (retx_q || !empty);
         assign do_pop    = may_start && !inhibit && !retx_q && !empty;

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               state_q  <= S_IDLE;
               div_q    <= '0;
               bit_q    <= '0;
               hold_q   <= '0;
               retx_q   <= 1'b0;
               clk_o_q  <= 1'b1;
               data_o_q <= 1'b1;
            end else if (do_start) begin
               state_q  <= S_START;
               div_q    <= '0;
               retx_q   <= 1'b0;
               clk_o_q  <= 1'b1;
               data_o_q <= 1'b0;
               if (do_pop) hold_q <= mem[rd_ptr_q[FIFO_BITS-1:0]];
            end else begin
               unique case (state_q)
                  S_START, S_DATA, S_PARITY: begin
                     if (inhibit) begin
                        state_q  <= S_HOLD;
                        div_q    <= '0;
                        retx_q   <= 1'b1;
                        clk_o_q  <= 1'b1;
                        data_o_q <= 1'b1;
                     end else if (bit_end) begin
                        div_q   <= '0;
                        clk_o_q <= 1'b1;
                        if (state_q == S_START) begin
                           state_q  <= S_DATA;
                           bit_q    <= '0;
                           data_o_q <= hold_q[0];
                        end else if (state_q == S_DATA && bit_q != 3'd7) begin
                           bit_q    <= bit_q + 3'd1;
                           data_o_q <= hold_q[bit_q + 3'd1];
                        end else if (state_q == S_DATA) begin
                           state_q  <= S_PARITY;
                           data_o_q <= ~^hold_q;
                        end else begin
                           state_q  <= S_STOP;
                           data_o_q <= 1'b1;
                        end
                     end else begin
                        div_q <= div_q + 1'b1;
                        if (half_end) clk_o_q <= 1'b0;
                     end
                  end
                  S_STOP: begin
                     if (bit_end) begin
                        state_q  <= S_GAP;
                        div_q    <= '0;
                        clk_o_q  <= 1'b1;
                        data_o_q <= 1'b1;
                     end else begin
                        div_q <= div_q + 1'b1;
                        if (half_end) clk_o_q <= 1'b0;
                     end
                  end
                  S_GAP: begin
                     if (bit_end) begin
                        state_q <= S_IDLE;
                        div_q   <= '0;
                     end else begin
                        div_q <= div_q + 1'b1;
                     end
                  end
                  S_HOLD: begin
                     if (released) begin
                        state_q <= S_GAP;
                        div_q   <= '0;
                     end
                  end
                  default: begin
                     state_q <= S_IDLE;
                     div_q   <= '0;
                  end
               endcase
            end
         end

         assign fifo_full[gi]    = full_q;
         assign overflow[gi]     = ovf_q;
         assign tx_busy[gi]      = (state_q != S_IDLE);
         assign ps2_clk_out[gi]  = clk_o_q;
         assign ps2_data_out[gi] = data_o_q;
      end
   endgenerate
endmodule

// File: tb/tb_ps2_multi_tx.sv
// Directed testbench for ps2_multi_tx (CHANNELS=2, FIFO_BITS=3, CLK_DIV=4); a line monitor decodes frames.
module tb_ps2_multi_tx;
   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [1:0] wr_chan = 2'd0;
   logic [7:0] wr_data = 8'd0;
   logic [1:0] ps2_clk_in = 2'b11;
   logic [1:0] fifo_full, overflow, tx_busy, ps2_clk_out, ps2_data_out;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   ps2_multi_tx #(.CHANNELS(2), .FIFO_BITS(3), .CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_chan(wr_chan), .wr_data(wr_data),
      .fifo_full(fifo_full), .overflow(overflow), .tx_busy(tx_busy),
      .ps2_clk_in(ps2_clk_in), .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line monitor: shifts data in on every falling PS/2 clock; a long high run discards a partial frame.
   int          cnt [2] = '{0, 0};
   int          hi_run [2] = '{0, 0};
   int          lo_run [2] = '{0, 0};
   int          falls [2] = '{0, 0};
   int          dlow [2] = '{0, 0};
   int          last_start [2] = '{0, 0};
   logic [10:0] bits [2];
   logic [1:0]  prev_clk = 2'b11;
   int          low_err = 0;
   int          frame_err = 0;
   logic [7:0]  rx0 [$];
   logic [7:0]  rx1 [$];

   always @(negedge clk) begin
      for (int c = 0; c < 2; c++) begin
         if (ps2_data_out[c[0]] === 1'b0) dlow[c[0]]++;
         if (ps2_clk_out[c[0]] === 1'b1) begin
            if (!prev_clk[c[0]] && lo_run[c[0]] != CLK_DIV) low_err++;
            lo_run[c[0]] = 0;
            hi_run[c[0]]++;
            if (hi_run[c[0]] > CLK_DIV + 2) cnt[c[0]] = 0;
         end else begin
            hi_run[c[0]] = 0;
            lo_run[c[0]]++;
            if (prev_clk[c[0]]) begin
               if (cnt[c[0]] == 0) last_start[c[0]] = cyc;
               falls[c[0]]++;
               bits[c[0]] = {ps2_data_out[c[0]], bits[c[0]][10:1]};
               cnt[c[0]]++;
               if (cnt[c[0]] == 11) begin
                  cnt[c[0]] = 0;
                  if (bits[c[0]][0] !== 1'b0 || bits[c[0]][10] !== 1'b1 ||
                      bits[c[0]][9] !== ~^bits[c[0]][8:1]) frame_err++;
                  if (c == 0) rx0.push_back(bits[c[0]][8:1]);
                  else rx1.push_back(bits[c[0]][8:1]);
                  $display("frame ch%0d byte 0x%02h raw %b at cycle %0d", c, bits[c[0]][8:1], bits[c[0]], cyc);
               end
            end
         end
         prev_clk[c[0]] = ps2_clk_out[c[0]];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input int limit, input string tag);
      int n = 0;
      while (tx_busy !== 2'b00 && n < limit) begin
         tick();
         n++;
      end
      checks++;
      if (tx_busy !== 2'b00) begin
         errors++;
         $display("FAIL %s_timeout: tx_busy=%b after %0d cycles, required 00", tag, tx_busy, limit);
      end
   endtask

   task automatic test_reset();
      repeat (3) tick();
      checks += 5;
      if (ps2_clk_out !== 2'b11) begin errors++; $display("FAIL reset_clk: got %b want 11", ps2_clk_out); end
      if (ps2_data_out !== 2'b11) begin errors++; $display("FAIL reset_data: got %b want 11", ps2_data_out); end
      if (fifo_full !== 2'b00) begin errors++; $display("FAIL reset_full: got %b want 00", fifo_full); end
      if (overflow !== 2'b00) begin errors++; $display("FAIL reset_ovf: got %b want 00", overflow); end
      if (tx_busy !== 2'b00) begin errors++; $display("FAIL reset_busy: got %b want 00", tx_busy); end
      reset_n = 1'b1;
      repeat (2) tick();
      $display("reset released");
   endtask

   task automatic test_basic_frame();
      int b0 = rx0.size();
      int f0 = falls[0], f1 = falls[1], d1 = dlow[1], le = low_err, fe = frame_err;
      int n = 1;
      wr_en = 1'b1; wr_chan = 2'd0; wr_data = 8'h1C;
      tick();
      wr_en = 1'b0;
      $display("write ch0 0x1C");
      checks += 2;
      if (ps2_data_out[0] !== 1'b1) begin errors++; $display("FAIL basic_pre_data: got %b want 1", ps2_data_out[0]); end
      if (tx_busy[0] !== 1'b0) begin errors++; $display("FAIL basic_pre_busy: got %b want 0", tx_busy[0]); end
      tick();
      checks += 2;
      if (ps2_data_out[0] !== 1'b0) begin errors++; $display("FAIL basic_start_data: got %b want 0", ps2_data_out[0]); end
      if (tx_busy[0] !== 1'b1) begin errors++; $display("FAIL basic_start_busy: got %b want 1", tx_busy[0]); end
      while (n < 300) begin
         tick();
         if (tx_busy[0] !== 1'b1) break;
         n++;
      end
      checks += 7;
      if (n != 96) begin errors++; $display("FAIL basic_busy_len: got %0d want 96", n); end
      if (rx0.size() - b0 != 1) begin errors++; $display("FAIL basic_count: got %0d want 1", rx0.size() - b0); end
      else if (bits[0] !== 11'b1_0_00011100_0) begin errors++; $display("FAIL basic_bits: got %b want 10000111000", bits[0]); end
      if (falls[0] - f0 != 11) begin errors++; $display("FAIL basic_falls: got %0d want 11", falls[0] - f0); end
      if (low_err != le) begin errors++; $display("FAIL basic_low_width: %0d bad low pulses, want 0", low_err - le); end
      if (frame_err != fe) begin errors++; $display("FAIL basic_framing: %0d bad frames, want 0", frame_err - fe); end
      if (falls[1] != f1 || dlow[1] != d1) begin
         errors++; $display("FAIL basic_ch1_quiet: falls %0d data-low %0d, want 0 0", falls[1] - f1, dlow[1] - d1);
      end
   endtask

   task automatic test_overflow();
      int b0 = rx0.size();
      for (int i = 1; i <= 10; i++) begin
         wr_en = 1'b1; wr_chan = 2'd0; wr_data = 8'(i);
         if (i == 10) begin
            checks++;
            if (fifo_full[0] !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b want 1", fifo_full[0]); end
         end
         tick();
         $display("write ch0 0x%02h", i);
      end
      wr_en = 1'b0;
      checks += 2;
      if (overflow[0] !== 1'b1) begin errors++; $display("FAIL ovf_ch0: got %b want 1", overflow[0]); end
      if (overflow[1] !== 1'b0) begin errors++; $display("FAIL ovf_ch1: got %b want 0", overflow[1]); end
      wait_idle(1500, "ovf");
      checks += 2;
      if (rx0.size() - b0 != 9) begin
         errors++; $display("FAIL ovf_count: got %0d want 9", rx0.size() - b0);
      end else begin
         for (int i = 0; i < 9; i++) begin
            checks++;
            if (rx0[b0 + i] !== 8'(i + 1)) begin
               errors++; $display("FAIL ovf_byte%0d: got 0x%02h want 0x%02h", i, rx0[b0 + i], 8'(i + 1));
            end
         end
      end
      if (fifo_full[0] !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b want 0", fifo_full[0]); end
   endtask

   task automatic test_inhibit();
      int b0 = rx0.size();
      int f0 = falls[0], fe = frame_err;
`ifdef PS2_INHIBIT_EN
      logic exp_data = 1'b1;
      int   exp_falls = 15;
`else
      logic exp_data = 1'b0;
      int   exp_falls = 11;
`endif
      wr_en = 1'b1; wr_chan = 2'd0; wr_data = 8'hF0;
      tick();
      wr_en = 1'b0;
      $display("write ch0 0xF0, inhibit during data bit 3");
      repeat (33) tick();
      ps2_clk_in[0] = 1'b0;
      repeat (3) tick();
      checks += 2;
      if (ps2_clk_out[0] !== 1'b1) begin errors++; $display("FAIL inh_clk: got %b want 1", ps2_clk_out[0]); end
      if (ps2_data_out[0] !== exp_data) begin errors++; $display("FAIL inh_data: got %b want %b", ps2_data_out[0], exp_data); end
      repeat (97) tick();
      ps2_clk_in[0] = 1'b1;
      wait_idle(1000, "inh");
      checks += 3;
      if (rx0.size() - b0 != 1) begin errors++; $display("FAIL inh_count: got %0d want 1", rx0.size() - b0); end
      else if (rx0[b0] !== 8'hF0) begin errors++; $display("FAIL inh_byte: got 0x%02h want 0xF0", rx0[b0]); end
      if (falls[0] - f0 != exp_falls) begin errors++; $display("FAIL inh_falls: got %0d want %0d", falls[0] - f0, exp_falls); end
      if (frame_err != fe) begin errors++; $display("FAIL inh_framing: %0d bad frames, want 0", frame_err - fe); end
   endtask

   task automatic test_reset_mid_frame();
      int f0, f1, d0, d1, b0;
      logic [7:0] bytes [4] = '{8'hAA, 8'h11, 8'h22, 8'h33};
      checks++;
      if (overflow[0] !== 1'b1) begin errors++; $display("FAIL rst_sticky_ovf: got %b want 1", overflow[0]); end
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_chan = 2'd0; wr_data = bytes[i];
         tick();
         $display("write ch0 0x%02h", bytes[i]);
      end
      wr_en = 1'b0;
      repeat (48) tick();
      checks++;
      if (tx_busy[0] !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", tx_busy[0]); end
      #2 reset_n = 1'b0;
      #1;
      $display("reset asserted mid-frame");
      checks += 5;
      if (ps2_clk_out !== 2'b11) begin errors++; $display("FAIL rst_clk: got %b want 11", ps2_clk_out); end
      if (ps2_data_out !== 2'b11) begin errors++; $display("FAIL rst_data: got %b want 11", ps2_data_out); end
      if (fifo_full !== 2'b00) begin errors++; $display("FAIL rst_full: got %b want 00", fifo_full); end
      if (overflow !== 2'b00) begin errors++; $display("FAIL rst_ovf: got %b want 00", overflow); end
      if (tx_busy !== 2'b00) begin errors++; $display("FAIL rst_busy: got %b want 00", tx_busy); end
      repeat (2) tick();
      reset_n = 1'b1;
      f0 = falls[0]; f1 = falls[1]; d0 = dlow[0]; d1 = dlow[1]; b0 = rx0.size();
      repeat (300) tick();
      checks += 3;
      if (falls[0] != f0 || falls[1] != f1) begin
         errors++; $display("FAIL rst_quiet_clk: falls %0d %0d want 0 0", falls[0] - f0, falls[1] - f1);
      end
      if (dlow[0] != d0 || dlow[1] != d1) begin
         errors++; $display("FAIL rst_quiet_data: data-low %0d %0d want 0 0", dlow[0] - d0, dlow[1] - d1);
      end
      if (tx_busy !== 2'b00 || rx0.size() != b0) begin
         errors++; $display("FAIL rst_quiet_busy: busy %b frames %0d want 00 0", tx_busy, rx0.size() - b0);
      end
   endtask

   task automatic test_interleaved();
      int b0 = rx0.size(), b1 = rx1.size();
      int f0 = falls[0], f1 = falls[1], le = low_err, fe = frame_err;
      wr_en = 1'b1; wr_chan = 2'd0; wr_data = 8'h12;
      tick();
      $display("write ch0 0x12");
      wr_chan = 2'd1; wr_data = 8'h34;
      tick();
      $display("write ch1 0x34");
      checks += 2;
      if (ps2_data_out[0] !== 1'b0) begin errors++; $display("FAIL il_ch0_start: got %b want 0", ps2_data_out[0]); end
      if (ps2_data_out[1] !== 1'b1) begin errors++; $display("FAIL il_ch1_pre: got %b want 1", ps2_data_out[1]); end
      wr_chan = 2'd3; wr_data = 8'h55;
      tick();
      wr_en = 1'b0;
      $display("write ch3 0x55 (no such channel)");
      checks++;
      if (ps2_data_out[1] !== 1'b0) begin errors++; $display("FAIL il_ch1_start: got %b want 0", ps2_data_out[1]); end
      wait_idle(400, "il");
      checks += 7;
      if (rx0.size() - b0 != 1) begin errors++; $display("FAIL il_ch0_count: got %0d want 1", rx0.size() - b0); end
      else if (rx0[b0] !== 8'h12) begin errors++; $display("FAIL il_ch0_byte: got 0x%02h want 0x12", rx0[b0]); end
      if (rx1.size() - b1 != 1) begin errors++; $display("FAIL il_ch1_count: got %0d want 1", rx1.size() - b1); end
      else if (rx1[b1] !== 8'h34) begin errors++; $display("FAIL il_ch1_byte: got 0x%02h want 0x34", rx1[b1]); end
      if (last_start[1] - last_start[0] != 1) begin
         errors++; $display("FAIL il_offset: got %0d cycles want 1", last_start[1] - last_start[0]);
      end
      if (falls[0] - f0 != 11 || falls[1] - f1 != 11) begin
         errors++; $display("FAIL il_falls: got %0d %0d want 11 11", falls[0] - f0, falls[1] - f1);
      end
      if (low_err != le || frame_err != fe) begin
         errors++; $display("FAIL il_framing: low %0d frame %0d want 0 0", low_err - le, frame_err - fe);
      end
      if (overflow !== 2'b00) begin errors++; $display("FAIL il_ovf: got %b want 00", overflow); end
      if (fifo_full !== 2'b00) begin errors++; $display("FAIL il_full: got %b want 00", fifo_full); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_overflow();
      test_inhibit();
      test_reset_mid_frame();
      test_interleaved();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
